imem_loader: RTL

- Program loader that writes the instruction memory through its write port (write enable, write data, byte address) from a byte stream received over a valid/ready handshake.
- Sits between a host byte source (UART receiver or testbench) and the instruction memory.
- Holds the core in reset while a load is in progress.
- Stream format: a 4-byte little-endian word count N, then N 32-bit words, each little-endian.

---
 rtl/imem_loader.sv | 124 ++++++++++++
 1 files changed

// File: rtl/imem_loader.sv
// Program loader: receives a little-endian word count and data words over a byte
// valid/ready stream and writes them into instruction memory while holding the core in reset.
module imem_loader #(
   parameter int DATA      = 32,
   parameter int ADDR      = 32,
   parameter int MEM_DEPTH = 256
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   input  logic            in_valid,
   input  logic [7:0]      in_data,
   output logic            in_ready,
   output logic            WE,
   output logic [DATA-1:0] WD,
   output logic [ADDR-1:0] PC,
   output logic            busy,
   output logic            cpu_hold,
   output logic            done,
   output logic            err
);

   localparam int CW = $clog2(MEM_DEPTH + 1);

   typedef enum logic [2:0] {
      S_IDLE, S_HDR, S_CHECK, S_DATA, S_WRITE, S_DONE, S_ERR
   } state_t;

   state_t          state, state_nx;
   logic [1:0]      byte_idx;
   logic [31:0]     n_q;
   logic [CW-1:0]   word_cnt;
   logic [CW-1:0]   word_cnt_inc;
   logic [23:0]     shadow;
   logic            xfer;
   logic            last_word;
   logic            oversize;

   assign xfer         = in_valid && in_ready;
   assign word_cnt_inc = word_cnt + CW'(1);
   assign last_word    = ({{(32-CW){1'b0}}, word_cnt_inc} == n_q);
   assign oversize     = (n_q > 32'(MEM_DEPTH));

   // NOTE: sequential state uses non-blocking assignments and an asynchronous reset
   // so every registered output drops the moment rst rises, without waiting for clk.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= S_IDLE;
      else     state <= state_nx;
   end

   // NOTE: state_nx gets a default before the case so no path leaves it unassigned,
   // which would otherwise infer a latch.
   always_comb begin
      state_nx = state;
      case (state)
         S_IDLE, S_DONE, S_ERR: if (start) state_nx = S_HDR;
         S_HDR:   if (xfer && byte_idx == 2'd3) state_nx = S_CHECK;
         S_CHECK: begin
            if (n_q == 32'd0)  state_nx = S_DONE;
            else if (oversize) state_nx = S_ERR;
            else               state_nx = S_DATA;
         end
         S_DATA:  if (xfer && byte_idx == 2'd3) state_nx = S_WRITE;
         S_WRITE: state_nx = last_word ? S_DONE : S_DATA;
         default: state_nx = S_IDLE;
      endcase
   end

   always_comb begin
      in_ready = (state == S_HDR) || (state == S_DATA);
      WE       = (state == S_WRITE);
      busy     = (state == S_HDR) || (state == S_CHECK) ||
                 (state == S_DATA) || (state == S_WRITE);
      cpu_hold = busy;
      done     = (state == S_DONE);
      err      = (state == S_ERR);
   end

   // WD is loaded only when the 4th byte lands, so it stays stable outside WRITE.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         byte_idx <= '0;
         n_q      <= '0;
         word_cnt <= '0;
         shadow   <= '0;
         WD       <= '0;
         PC       <= '0;
      end else begin
         case (state)
            S_IDLE, S_DONE, S_ERR: begin
               if (start) begin
                  byte_idx <= '0;
                  n_q      <= '0;
                  PC       <= '0;
               end
            end
            S_HDR: begin
               if (xfer) begin
                  n_q[{byte_idx, 3'b000} +: 8] <= in_data;
                  byte_idx <= byte_idx + 2'd1;
               end
            end
            S_CHECK: word_cnt <= '0;
            S_DATA: begin
               if (xfer) begin
                  case (byte_idx)
                     2'd0:    shadow[7:0]   <= in_data;
                     2'd1:    shadow[15:8]  <= in_data;
                     2'd2:    shadow[23:16] <= in_data;
                     default: WD            <= {in_data, shadow};
                  endcase
                  byte_idx <= byte_idx + 2'd1;
               end
            end
            S_WRITE: begin
               word_cnt <= word_cnt_inc;
               PC       <= PC + ADDR'(4);
            end
            default: ;
         endcase
      end
   end

endmodule
